// File: rtl/alu_op_sequencer.sv
// Issues a small stored program of ALU micro-ops, waits on alu_done, then strobes reg_write once per op.
// Per op: 1 fetch + >=2 wait + 1 write cycle; start and prog_we are ignored while busy.
module alu_op_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              alu_done,
  input  logic [3:0]        alu_y,
  input  logic              alu_c,
  output logic [1:0]        a,
  output logic [1:0]        b,
  output logic [1:0]        ctrl,
  output logic [1:0]        reg_addr,
  output logic              reg_write,
  output logic              busy,
  output logic              seq_done,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        last_y,
  output logic [ADDR_W:0]   carry_cnt
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [1:0] ctrl;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] dest;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  instr_t              mem_q [DEPTH];
  instr_t              mem_d [DEPTH];
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [1:0]          a_q, a_d;
  logic [1:0]          b_q, b_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [1:0]          reg_addr_q, reg_addr_d;
  logic                error_q, error_d;
  logic [3:0]          last_y_q, last_y_d;
  logic [LEN_W-1:0]    carry_cnt_q, carry_cnt_d;
  logic [LEN_W-1:0]    len_clamped;
  instr_t              cur_instr;

  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign cur_instr   = mem_q[pc_q];

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    len_d       = len_q;
    pc_d        = pc_q;
    wait_cnt_d  = wait_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    reg_addr_d  = reg_addr_q;
    error_d     = error_q;
    last_y_d    = last_y_q;
    carry_cnt_d = carry_cnt_q;

    case (state_q)
      S_IDLE: begin
        // The write lands at the same edge as start, so FETCH already sees it.
        if (prog_we && reset) begin
          mem_d[prog_addr] = instr_t'(prog_data);
        end
        if (start) begin
          len_d       = len_clamped;
          pc_d        = '0;
          error_d     = 1'b0;
          carry_cnt_d = '0;
          state_d     = (len_clamped == '0) ? S_FIN : S_FETCH;
        end
      end

      S_FETCH: begin
        a_d        = cur_instr.a;
        b_d        = cur_instr.b;
        ctrl_d     = cur_instr.ctrl;
        reg_addr_d = cur_instr.dest;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A done seen in the first wait cycle belongs to the previous op.
        if ((wait_cnt_q != '0) && alu_done) begin
          last_y_d = alu_y;
          if (alu_c && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + 1'b1;
          end
          state_d = S_WRITE;
        end else if (wait_cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end

      S_WRITE: begin
        if ({1'b0, pc_q} == (len_q - 1'b1)) begin
          state_d = S_FIN;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pc_q        <= '0;
      wait_cnt_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      reg_addr_q  <= '0;
      error_q     <= 1'b0;
      last_y_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pc_q        <= pc_d;
      wait_cnt_q  <= wait_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      reg_addr_q  <= reg_addr_d;
      error_q     <= error_d;
      last_y_q    <= last_y_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  // Program storage survives reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a         = a_q;
  assign b         = b_q;
  assign ctrl      = ctrl_q;
  assign reg_addr  = reg_addr_q;
  assign pc        = pc_q;
  assign error     = error_q;
  assign last_y    = last_y_q;
  assign carry_cnt = carry_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign seq_done  = (state_q == S_FIN);
  assign reg_write = (state_q == S_WRITE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed table of runs, reset abort, and randomized runs vs a schedule model.
module tb_alu_op_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 15;
  localparam int NCYC  = 300;

  logic       clk = 1'b0;
  logic       reset, prog_we, start, alu_done, alu_c;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] prog_len, alu_y;
  logic [1:0] a, b, ctrl, reg_addr;
  logic       reg_write, busy, seq_done, error;
  logic [2:0] pc;
  logic [3:0] last_y, carry_cnt;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(8), .ADDR_W(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .alu_done(alu_done),
    .alu_y(alu_y), .alu_c(alu_c), .a(a), .b(b), .ctrl(ctrl), .reg_addr(reg_addr),
    .reg_write(reg_write), .busy(busy), .seq_done(seq_done), .error(error), .pc(pc),
    .last_y(last_y), .carry_cnt(carry_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mem_m [DEPTH];
  int delay_plan [DEPTH];

  typedef struct {
    int len;
    int dly;
    int exp_wr;
    int exp_fin;
    int exp_err;
    bit chk_y;
    int exp_y;
    int exp_c;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {carry/borrow, result}.
  function automatic logic [4:0] alu_model(input logic [7:0] ins);
    logic [3:0] x, z;
    x = {2'b00, ins[5:4]};
    z = {2'b00, ins[3:2]};
    case (ins[7:6])
      2'd0:    return {1'b0, x + z};
      2'd1:    return {(x < z), x - z};
      2'd2:    return {1'b0, x & z};
      default: return {1'b0, x | z};
    endcase
  endfunction

  task automatic load(input int addr, input logic [7:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[2:0];
    prog_data = data;
    mem_m[addr] = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One run from start to the cycle after seq_done, checked cycle by cycle against an op schedule.
  task automatic run(input int len_in, input bit junk, input bit same_wr,
                     output int n_wr, output int fin_obs, output int err_obs,
                     output int y_obs, output int c_obs);
    bit         exp_wr   [NCYC];
    bit         drv_done [NCYC];
    logic [4:0] drv_yc   [NCYC];
    int         wr_op    [NCYC];
    int L, t, fin, ncarry, cw, wa;
    bit eerr;
    logic [4:0] r;
    logic [7:0] ins;
    for (int k = 0; k < NCYC; k++) begin
      exp_wr[k]   = 1'b0;
      drv_done[k] = 1'($urandom);
      drv_yc[k]   = 5'($urandom);
      wr_op[k]    = 0;
    end
    @(negedge clk);
    prog_we = 1'b0;
    if (same_wr) begin
      wa = $urandom_range(0, DEPTH - 1);
      prog_we   = 1'b1;
      prog_addr = wa[2:0];
      prog_data = 8'($urandom);
      mem_m[wa] = prog_data;
    end
    start    = 1'b1;
    prog_len = 4'(len_in);
    alu_done = 1'b0;
    L = (len_in > DEPTH) ? DEPTH : len_in;
    t = 1; eerr = 1'b0; ncarry = 0; fin = 1;
    for (int i = 0; i < L && !eerr; i++) begin
      r = alu_model(mem_m[i]);
      if (delay_plan[i] > TMO) begin
        for (int j = 0; j <= TMO; j++) drv_done[t + j] = 1'b0;
        fin  = t + TMO + 1;
        eerr = 1'b1;
      end else begin
        cw = (delay_plan[i] < 2) ? 2 : delay_plan[i];
        for (int j = 0; j <= cw; j++) begin
          drv_done[t + j] = (j >= delay_plan[i]);
          if (drv_done[t + j]) drv_yc[t + j] = r;
        end
        exp_wr[t + cw + 1] = 1'b1;
        wr_op[t + cw + 1]  = i;
        ncarry += int'(r[4]);
        t = t + cw + 2;
      end
    end
    if (!eerr) fin = t;
    n_wr = 0; fin_obs = -1;
    for (int tt = 1; tt <= fin + 1; tt++) begin
      @(posedge clk);
      @(negedge clk);
      if (tt == 1) begin
        check("error_cleared_on_start", int'(error), 0);
        check("pc_start", int'(pc), 0);
        check("carry_cnt_start", int'(carry_cnt), 0);
      end
      check("reg_write", int'(reg_write), int'(exp_wr[tt]));
      check("seq_done", int'(seq_done), (tt == fin) ? 1 : 0);
      check("busy", int'(busy), (tt <= fin) ? 1 : 0);
      if (exp_wr[tt]) begin
        ins = mem_m[wr_op[tt]];
        check("operands", int'({a, b, ctrl, reg_addr}),
              int'({ins[5:4], ins[3:2], ins[7:6], ins[1:0]}));
        check("pc_at_write", int'(pc), wr_op[tt]);
        r = alu_model(ins);
        check("last_y_at_write", int'(last_y), int'(r[3:0]));
      end
      if (tt >= fin) begin
        check("error_end", int'(error), eerr ? 1 : 0);
        check("carry_cnt_end", int'(carry_cnt), ncarry);
      end
      n_wr += int'(reg_write);
      if (seq_done) fin_obs = tt;
      alu_done = drv_done[tt];
      {alu_c, alu_y} = drv_yc[tt];
      if (junk && tt <= fin) begin
        start     = 1'($urandom);
        prog_we   = 1'($urandom);
        prog_addr = 3'($urandom);
        prog_data = 8'($urandom);
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
    end
    alu_done = 1'b0;
    err_obs  = int'(error);
    y_obs    = int'(last_y);
    c_obs    = int'(carry_cnt);
  endtask

  initial begin
    vec_t tbl [8];
    logic [7:0] fixed_prog [DEPTH];
    int n_wr, fin_obs, err_obs, y_obs, c_obs, L, nw;

    fixed_prog[0] = 8'h24; fixed_prog[1] = 8'h65; fixed_prog[2] = 8'h3E; fixed_prog[3] = 8'h5B;
    fixed_prog[4] = 8'hB4; fixed_prog[5] = 8'h4D; fixed_prog[6] = 8'hE6; fixed_prog[7] = 8'hFF;
    //            len dly wr fin err chk y  c
    tbl[0] = '{1,  3,  1, 6,   0, 1, 3, 0};
    tbl[1] = '{2,  2,  2, 9,   0, 1, 1, 0};
    tbl[2] = '{0,  2,  0, 1,   0, 0, 0, 0};
    tbl[3] = '{3,  99, 0, 17,  1, 0, 0, 0};
    tbl[4] = '{15, 2,  8, 33,  0, 1, 3, 2};
    tbl[5] = '{1,  0,  1, 5,   0, 1, 3, 0};
    tbl[6] = '{8,  15, 8, 137, 0, 1, 3, 2};
    tbl[7] = '{1,  16, 0, 17,  1, 0, 0, 0};

    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; alu_done = 1'b0; alu_y = '0; alu_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({a, b, ctrl, reg_addr, reg_write, busy, seq_done, error,
                                 pc, last_y, carry_cnt}), 0);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(i, fixed_prog[i]);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < DEPTH; i++) delay_plan[i] = tbl[v].dly;
      run(tbl[v].len, 1'b0, 1'b0, n_wr, fin_obs, err_obs, y_obs, c_obs);
      check($sformatf("tbl%0d_writes", v), n_wr, tbl[v].exp_wr);
      check($sformatf("tbl%0d_fin", v), fin_obs, tbl[v].exp_fin);
      check($sformatf("tbl%0d_error", v), err_obs, tbl[v].exp_err);
      if (tbl[v].chk_y) begin
        check($sformatf("tbl%0d_last_y", v), y_obs, tbl[v].exp_y);
        check($sformatf("tbl%0d_carry", v), c_obs, tbl[v].exp_c);
      end
    end

    // Reset during the first wait cycle of op 0 aborts the run.
    @(negedge clk);
    start = 1'b1; prog_len = 4'd3; alu_done = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; alu_done = 1'b1;
    nw = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      nw += int'(reg_write);
      check("abort_outputs", int'({a, b, ctrl, reg_addr, busy, seq_done, error,
                                   pc, last_y, carry_cnt}), 0);
    end
    check("abort_no_write", nw, 0);
    reset = 1'b1; alu_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) delay_plan[i] = 2;
    run(3, 1'b0, 1'b0, n_wr, fin_obs, err_obs, y_obs, c_obs);
    check("rerun_writes", n_wr, 3);
    check("rerun_fin", fin_obs, 13);
    check("rerun_last_y", y_obs, 6);

    // Randomized programs, lengths, ALU latencies and ignored inputs while busy.
    for (int n = 0; n < 40; n++) begin
      nw = $urandom_range(0, DEPTH);
      for (int k = 0; k < nw; k++) load($urandom_range(0, DEPTH - 1), 8'($urandom));
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 11) == 0) delay_plan[i] = 16 + $urandom_range(0, 5);
        else if ($urandom_range(0, 7) == 0) delay_plan[i] = $urandom_range(6, 15);
        else delay_plan[i] = $urandom_range(0, 5);
      end
      L = $urandom_range(0, 15);
      run(L, 1'($urandom), 1'($urandom), n_wr, fin_obs, err_obs, y_obs, c_obs);
      check("rand_seq_done_seen", (fin_obs > 0) ? 1 : 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
